// File: rtl/uart_frame_check_if.sv
// Bundle between a bit-sampling front end and the UART frame checker:
// sampled-bit strobe, framing options and the checker's result outputs.
interface uart_frame_check_if #(
  parameter int DATA_WIDTH    = 8,
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     en;
  logic                     edge_done;
  logic                     samp_out;
  logic                     par_en;
  logic                     par_odd;
  logic                     clr_cnt;
  logic [DATA_WIDTH-1:0]    data_out;
  logic                     data_valid;
  logic                     start_err;
  logic                     par_err;
  logic                     stop_err;
  logic                     frame_busy;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;

  // Strobe semantics: a bit is offered when edge_done=1 and consumed only while en=1;
  // there is no back-pressure, so every enabled strobe is taken in that same cycle.
  modport master (
    output en, edge_done, samp_out, par_en, par_odd, clr_cnt,
    input  data_out, data_valid, start_err, par_err, stop_err, frame_busy, err_cnt
  );

  modport slave (
    input  en, edge_done, samp_out, par_en, par_odd, clr_cnt,
    output data_out, data_valid, start_err, par_err, stop_err, frame_busy, err_cnt
  );
endinterface

// File: rtl/uart_frame_check.sv
// UART frame checker: assembles start/data/parity/stop bits delivered as sample
// strobes, flags framing errors as single-cycle pulses and counts them.
module uart_frame_check #(
  parameter int DATA_WIDTH    = 8,
  parameter int STOP_BITS     = 1,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_check_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                  state, state_nx;
  logic [DATA_WIDTH-1:0]   shreg, shreg_nx;
  logic [DATA_WIDTH-1:0]   data_q, data_nx;
  logic [3:0]              cnt, cnt_nx;
  logic                    pe_q, pe_nx;
  logic                    po_q, po_nx;
  logic                    ferr_q, ferr_nx;
  logic                    dv_q, dv_nx;
  logic                    se_q, se_nx;
  logic                    pa_q, pa_nx;
  logic                    so_q, so_nx;
  logic [ERR_CNT_WIDTH-1:0] err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      shreg  <= '0;
      data_q <= '0;
      cnt    <= '0;
      pe_q   <= 1'b0;
      po_q   <= 1'b0;
      ferr_q <= 1'b0;
      dv_q   <= 1'b0;
      se_q   <= 1'b0;
      pa_q   <= 1'b0;
      so_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      shreg  <= shreg_nx;
      data_q <= data_nx;
      cnt    <= cnt_nx;
      pe_q   <= pe_nx;
      po_q   <= po_nx;
      ferr_q <= ferr_nx;
      dv_q   <= dv_nx;
      se_q   <= se_nx;
      pa_q   <= pa_nx;
      so_q   <= so_nx;
    end
  end

  // cnt counts data bits in DATA and stop bits in STOP; ferr_q remembers any
  // parity/stop error seen earlier in the frame so the word is not published.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    data_nx  = data_q;
    cnt_nx   = cnt;
    pe_nx    = pe_q;
    po_nx    = po_q;
    ferr_nx  = ferr_q;
    dv_nx    = 1'b0;
    se_nx    = 1'b0;
    pa_nx    = 1'b0;
    so_nx    = 1'b0;
    if (!bus.en) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (bus.edge_done) begin
      case (state)
        IDLE: begin
          if (bus.samp_out) begin
            se_nx = 1'b1;
          end else begin
            pe_nx    = bus.par_en;
            po_nx    = bus.par_odd;
            cnt_nx   = '0;
            ferr_nx  = 1'b0;
            state_nx = DATA;
          end
        end
        DATA: begin
          shreg_nx = {bus.samp_out, shreg[DATA_WIDTH-1:1]};
          if (cnt == 4'(DATA_WIDTH - 1)) begin
            cnt_nx   = '0;
            state_nx = pe_q ? PARITY : STOP;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        PARITY: begin
          if (bus.samp_out != (^shreg ^ po_q)) begin
            pa_nx   = 1'b1;
            ferr_nx = 1'b1;
          end
          state_nx = STOP;
        end
        STOP: begin
          if (!bus.samp_out) begin
            so_nx   = 1'b1;
            ferr_nx = 1'b1;
          end
          if (cnt == 4'(STOP_BITS - 1)) begin
            cnt_nx   = '0;
            state_nx = IDLE;
            if (!ferr_q && bus.samp_out) begin
              data_nx = shreg;
              dv_nx   = 1'b1;
            end
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Clear wins over a coincident increment; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || bus.clr_cnt) begin
      err_q <= '0;
    end else if ((se_q || pa_q || so_q) && (err_q != '1)) begin
      err_q <= err_q + 1'b1;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = dv_q;
  assign bus.start_err  = se_q;
  assign bus.par_err    = pa_q;
  assign bus.stop_err   = so_q;
  assign bus.frame_busy = (state != IDLE);
  assign bus.err_cnt    = err_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_uart_frame_check.sv
// Bench for uart_frame_check: one-stop-bit and two-stop-bit instances driven by
// directed and random frames, with a frame-level model feeding event scoreboards.
module tb_uart_frame_check;
  localparam int DW     = 8;
  localparam int CW     = 2;
  localparam int CNTMAX = (1 << CW) - 1;

  localparam logic [3:0] K_DV = 4'd1;
  localparam logic [3:0] K_SE = 4'd2;
  localparam logic [3:0] K_PA = 4'd3;
  localparam logic [3:0] K_SO = 4'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_frame_check_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus0 ();
  uart_frame_check_if #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) bus1 ();
  logic [1:0] st0, st1;

  uart_frame_check #(.DATA_WIDTH(DW), .STOP_BITS(1), .ERR_CNT_WIDTH(CW)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .dbg_state(st0)
  );
  uart_frame_check #(.DATA_WIDTH(DW), .STOP_BITS(2), .ERR_CNT_WIDTH(CW)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .dbg_state(st1)
  );

  // Drive-side and observe-side views indexed by instance number.
  logic          en_d[2], ed_d[2], sa_d[2], pe_d[2], po_d[2], clr_d[2];
  logic          dv_o[2], se_o[2], pa_o[2], so_o[2], busy_o[2];
  logic [DW-1:0] do_o[2];
  logic [CW-1:0] ec_o[2];
  logic [1:0]    st_o[2];

  assign bus0.en = en_d[0];  assign bus0.edge_done = ed_d[0];  assign bus0.samp_out = sa_d[0];
  assign bus0.par_en = pe_d[0];  assign bus0.par_odd = po_d[0];  assign bus0.clr_cnt = clr_d[0];
  assign bus1.en = en_d[1];  assign bus1.edge_done = ed_d[1];  assign bus1.samp_out = sa_d[1];
  assign bus1.par_en = pe_d[1];  assign bus1.par_odd = po_d[1];  assign bus1.clr_cnt = clr_d[1];

  assign dv_o[0] = bus0.data_valid;  assign se_o[0] = bus0.start_err;  assign pa_o[0] = bus0.par_err;
  assign so_o[0] = bus0.stop_err;    assign busy_o[0] = bus0.frame_busy;  assign do_o[0] = bus0.data_out;
  assign ec_o[0] = bus0.err_cnt;     assign st_o[0] = st0;
  assign dv_o[1] = bus1.data_valid;  assign se_o[1] = bus1.start_err;  assign pa_o[1] = bus1.par_err;
  assign so_o[1] = bus1.stop_err;    assign busy_o[1] = bus1.frame_busy;  assign do_o[1] = bus1.data_out;
  assign ec_o[1] = bus1.err_cnt;     assign st_o[1] = st1;

  int vectors    = 0;
  int miscompares = 0;

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];

  int          cnt_m[2];
  logic [DW-1:0] good_m[2];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_ev(input int s, input logic [15:0] ev);
    if (s == 0) exp_q0.push_back(ev);
    else        exp_q1.push_back(ev);
  endfunction

  function automatic void exp_err(input int s, input logic [3:0] kind);
    push_ev(s, {kind, 12'h000});
    cnt_m[s] = (cnt_m[s] >= CNTMAX) ? CNTMAX : cnt_m[s] + 1;
  endfunction

  // Monitor: every pulse cycle is one observed event, compared in order.
  task automatic mon_step(input int s);
    logic [15:0] ev, e;
    int n;
    n = int'(dv_o[s]) + int'(se_o[s]) + int'(pa_o[s]) + int'(so_o[s]);
    if (n == 0) return;
    vectors++;
    if (n > 1) begin
      miscompares++;
      $display("FAIL pulse_overlap dut%0d: %0d pulses high together, expected 1", s, n);
      return;
    end
    ev = dv_o[s] ? {K_DV, 4'h0, do_o[s]} : se_o[s] ? {K_SE, 12'h000} :
         pa_o[s] ? {K_PA, 12'h000} : {K_SO, 12'h000};
    if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
      miscompares++;
      $display("FAIL unexpected_event dut%0d: got %04h, expected none (t=%0t)", s, ev, $time);
      return;
    end
    e = (s == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    if (ev != e) begin
      miscompares++;
      $display("FAIL event dut%0d: got %04h, expected %04h (t=%0t)", s, ev, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_step(0);
      mon_step(1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int s, input logic b, input int gap);
    ed_d[s] = 1'b1;
    sa_d[s] = b;
    tick(1);
    ed_d[s] = 1'b0;
    sa_d[s] = 1'($urandom);
    if (gap > 0) tick(gap);
  endtask

  // Frame-level reference: decide the outcome from the frame contents, queue
  // the expected events, then put the bits on the line.
  task automatic send_frame(input int s, input logic start_bad, input logic [DW-1:0] data,
                            input logic pe, input logic po, input logic flip_par,
                            input logic [1:0] stop_lo, input int abort_at,
                            input int gapmax, input logic scramble);
    int  nstop;
    logic bad, pbit;
    nstop = (s == 0) ? 1 : 2;
    pbit  = (^data) ^ po ^ flip_par;
    if (start_bad) begin
      exp_err(s, K_SE);
    end else if (abort_at < 0) begin
      bad = 1'b0;
      if (pe && flip_par) begin
        exp_err(s, K_PA);
        bad = 1'b1;
      end
      for (int i = 0; i < nstop; i++) begin
        if (stop_lo[i]) begin
          exp_err(s, K_SO);
          bad = 1'b1;
        end
      end
      if (!bad) begin
        push_ev(s, {K_DV, 4'h0, data});
        good_m[s] = data;
      end
    end
    pe_d[s] = pe;
    po_d[s] = po;
    strobe(s, start_bad, $urandom_range(0, gapmax));
    if (start_bad) return;
    for (int i = 0; i < DW; i++) begin
      if (scramble) begin
        pe_d[s] = 1'($urandom);
        po_d[s] = 1'($urandom);
      end
      if (i == abort_at) begin
        en_d[s] = 1'b0;
        ed_d[s] = 1'($urandom);
        tick(1);
        en_d[s] = 1'b1;
        ed_d[s] = 1'b0;
        return;
      end
      strobe(s, data[i], $urandom_range(0, gapmax));
    end
    if (pe) strobe(s, pbit, $urandom_range(0, gapmax));
    for (int i = 0; i < nstop; i++) strobe(s, !stop_lo[i], $urandom_range(0, gapmax));
  endtask

  task automatic check_outputs_zero(input int s);
    check($sformatf("rst_data_out%0d", s), int'(do_o[s]), 0);
    check($sformatf("rst_busy%0d", s), int'(busy_o[s]), 0);
    check($sformatf("rst_err_cnt%0d", s), int'(ec_o[s]), 0);
    check($sformatf("rst_pulses%0d", s),
          int'({dv_o[s], se_o[s], pa_o[s], so_o[s]}), 0);
    check($sformatf("rst_state%0d", s), int'(st_o[s]), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    for (int s = 0; s < 2; s++) begin
      en_d[s] = 1'b1; ed_d[s] = 1'b0; sa_d[s] = 1'b1;
      pe_d[s] = 1'b0; po_d[s] = 1'b0; clr_d[s] = 1'b0;
      cnt_m[s] = 0;   good_m[s] = '0;
    end
    rst = 1'b1;
    tick(3);
    check_outputs_zero(0);
    check_outputs_zero(1);
    rst = 1'b0;
    tick(1);

    // 0xA5, even parity, correct parity bit, back-to-back strobes.
    send_frame(0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 2'b00, -1, 0, 1'b0);
    tick(2);
    check("a5_data_out", int'(do_o[0]), 'hA5);
    check("a5_err_cnt", int'(ec_o[0]), 0);
    check("a5_busy_after", int'(busy_o[0]), 0);

    // Start bit high, then a clean 0x3C without parity.
    send_frame(0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, -1, 0, 1'b0);
    check("start_err_busy", int'(busy_o[0]), 0);
    tick(2);
    check("start_err_cnt", int'(ec_o[0]), 1);
    send_frame(0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1, 1'b0);
    tick(2);
    check("3c_data_out", int'(do_o[0]), 'h3C);

    // Wrong parity bit: data_out keeps 0x3C.
    send_frame(0, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b1, 2'b00, -1, 0, 1'b0);
    tick(2);
    check("par_err_hold", int'(do_o[0]), 'h3C);
    check("par_err_cnt", int'(ec_o[0]), 2);

    // en dropped after four data bits, then 0x55.
    send_frame(0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 2'b00, 4, 0, 1'b0);
    check("abort_busy", int'(busy_o[0]), 0);
    check("abort_state", int'(st_o[0]), 0);
    tick(2);
    send_frame(0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 2'b00, -1, 2, 1'b0);
    tick(2);
    check("55_data_out", int'(do_o[0]), 'h55);
    check("55_err_cnt", int'(ec_o[0]), 2);

    // Two stop bits, 0x0F, second stop bit low.
    send_frame(1, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 2'b10, -1, 0, 1'b0);
    tick(2);
    check("stop2_hold", int'(do_o[1]), 0);
    check("stop2_err_cnt", int'(ec_o[1]), 1);

    // Random frames on both instances.
    for (int it = 0; it < 120; it++) begin
      int s, ab;
      s  = $urandom_range(0, 1);
      d  = DW'($urandom);
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, DW - 1) : -1;
      send_frame(s, ($urandom_range(0, 7) == 0), d, 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0),
                 {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)},
                 ab, $urandom_range(0, 3), 1'b1);
      tick(2);
      check($sformatf("rnd_data_out%0d", s), int'(do_o[s]), int'(good_m[s]));
      check($sformatf("rnd_err_cnt%0d", s), int'(ec_o[s]), cnt_m[s]);
      check($sformatf("rnd_busy%0d", s), int'(busy_o[s]), 0);
    end

    // Saturation and clear coincident with an error pulse.
    clr_d[0] = 1'b1;
    tick(1);
    clr_d[0] = 1'b0;
    cnt_m[0] = 0;
    check("clr_cnt", int'(ec_o[0]), 0);
    for (int i = 0; i < 4; i++)
      send_frame(0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00, -1, 1, 1'b0);
    tick(2);
    check("sat_err_cnt", int'(ec_o[0]), CNTMAX);
    push_ev(0, {K_SE, 12'h000});
    strobe(0, 1'b1, 0);
    clr_d[0] = 1'b1;
    tick(1);
    clr_d[0] = 1'b0;
    cnt_m[0] = 0;
    check("clr_over_inc", int'(ec_o[0]), 0);
    tick(1);
    check("clr_after", int'(ec_o[0]), 0);

    // Reset in the middle of the data bits.
    strobe(0, 1'b0, 0);
    strobe(0, 1'b1, 0);
    strobe(0, 1'b0, 0);
    strobe(0, 1'b1, 0);
    check("mid_busy", int'(busy_o[0]), 1);
    rst = 1'b1;
    tick(1);
    check_outputs_zero(0);
    rst = 1'b0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    good_m[0] = '0; good_m[1] = '0;
    tick(1);
    check("post_rst_busy", int'(busy_o[0]), 0);
    send_frame(0, 1'b0, 8'hC3, 1'b1, 1'b1, 1'b0, 2'b00, -1, 1, 1'b0);
    tick(2);
    check("post_rst_data", int'(do_o[0]), 'hC3);

    tick(3);
    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
